// File: rtl/rv32v_seq_pkg.sv
// rtl/rv32v_seq_pkg.sv - shared types and defaults for the rv32v execute-stage element sequencer
// Purpose: sequencer state encoding, default geometry and the element-group record.
// Ports: none (package).
package rv32v_seq_pkg;

    localparam int DEF_LANES = 2;
    localparam int DEF_VLMAX = 32;
    localparam int DEF_VL_W  = $clog2(DEF_VLMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        EMPTY = 2'd2
    } seq_state_t;

    // One element group as presented to the execute lanes (default geometry).
    typedef struct packed {
        logic [DEF_VL_W-1:0]  eidx;
        logic [DEF_LANES-1:0] mask;
        logic                 last;
        logic [4:0]           tag;
    } seq_group_t;

endpackage

// File: rtl/rv32v_ex_sequencer_if.sv
// rtl/rv32v_ex_sequencer_if.sv - decode-side handshake and lane-side group bus of the sequencer
// Purpose: bundles the instruction handshake from decode and the element-group outputs to the lanes.
// Ports: in_valid/in_ready/in_vl/in_tag (decode -> sequencer),
//        out_valid/out_eidx/out_mask/out_last/out_tag/done (sequencer -> lanes).
//        master = decode/lanes side, slave = sequencer.
interface rv32v_ex_sequencer_if
    import rv32v_seq_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int VL_W  = DEF_VL_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [VL_W-1:0]  in_vl;
    logic [4:0]       in_tag;
    logic             out_valid;
    logic [VL_W-1:0]  out_eidx;
    logic [LANES-1:0] out_mask;
    logic             out_last;
    logic [4:0]       out_tag;
    logic             done;

    modport master (
        output in_valid, in_vl, in_tag,
        input  in_ready, out_valid, out_eidx, out_mask, out_last, out_tag, done
    );

    modport slave (
        input  in_valid, in_vl, in_tag,
        output in_ready, out_valid, out_eidx, out_mask, out_last, out_tag, done
    );

endinterface

// File: rtl/rv32v_lane_mask_gen.sv
// rtl/rv32v_lane_mask_gen.sv - lane-enable and last-group generator
// Purpose: combinational lane enables for the group starting at eidx, and last-group flag.
// Ports: eidx (in, first element of group), vl (in, element count),
//        mask (out, bit i set when eidx+i < vl), last (out, eidx+LANES >= vl).
module rv32v_lane_mask_gen #(
    parameter int LANES = 2,
    parameter int VL_W  = 6
) (
    input  logic [VL_W-1:0]  eidx,
    input  logic [VL_W-1:0]  vl,
    output logic [LANES-1:0] mask,
    output logic             last
);

    // Comparisons are done one bit wider so eidx+offset can never wrap.
    logic [VL_W:0] w_eidx_x;
    logic [VL_W:0] w_vl_x;

    assign w_eidx_x = {1'b0, eidx};
    assign w_vl_x   = {1'b0, vl};

    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = (w_eidx_x + (VL_W+1)'(i)) < w_vl_x;
        end
    end

    assign last = (w_eidx_x + (VL_W+1)'(LANES)) >= w_vl_x;

endmodule

// File: rtl/rv32v_ex_sequencer.sv
// rtl/rv32v_ex_sequencer.sv - vector execute-stage element sequencer
// Purpose: accepts one vector instruction, walks its vl elements LANES at a time,
//          reports busy_ex to the hazard unit and honours stall_ex / flush_ex.
// Ports: CLK, RST (sync, active-high), stall_ex, flush_ex (in), busy_ex (out),
//        bus (slave modport: decode handshake in, element groups and done out).
module rv32v_ex_sequencer
    import rv32v_seq_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int VLMAX = DEF_VLMAX,
    parameter int VL_W  = $clog2(VLMAX + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  stall_ex,
    input  logic                  flush_ex,
    output logic                  busy_ex,
    rv32v_ex_sequencer_if.slave   bus
);

    seq_state_t      r_state, w_state_n;
    logic [VL_W-1:0] r_vl,    w_vl_n;
    logic [VL_W-1:0] r_eidx,  w_eidx_n;
    logic [4:0]      r_tag,   w_tag_n;

    logic [LANES-1:0] w_mask;
    logic             w_last;
    logic             w_run;
    logic             w_empty;
    logic             w_idle;
    logic             w_accept;
    logic [VL_W-1:0]  w_vl_clamp;

    rv32v_lane_mask_gen #(
        .LANES (LANES),
        .VL_W  (VL_W)
    ) u_mask_gen (
        .eidx (r_eidx),
        .vl   (r_vl),
        .mask (w_mask),
        .last (w_last)
    );

    assign w_run   = (r_state == RUN);
    assign w_empty = (r_state == EMPTY);
    assign w_idle  = (r_state == IDLE);

    assign w_vl_clamp = (bus.in_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : bus.in_vl;

    // A new instruction may enter on the final group of the current one, so
    // back-to-back instructions issue without a bubble.
    assign bus.in_ready = !RST && !flush_ex && !stall_ex && (w_idle || (w_run && w_last));
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign busy_ex       = w_run && !w_last;
    assign bus.done      = !flush_ex && !stall_ex && ((w_run && w_last) || w_empty);

    // Counters keep their values after retire, so group outputs are gated by RUN.
    assign bus.out_valid = w_run;
    assign bus.out_eidx  = w_run ? r_eidx : '0;
    assign bus.out_mask  = w_run ? w_mask : '0;
    assign bus.out_last  = w_run && w_last;
    assign bus.out_tag   = w_run ? r_tag : '0;

    always_comb begin
        w_state_n = r_state;
        w_vl_n    = r_vl;
        w_eidx_n  = r_eidx;
        w_tag_n   = r_tag;
        if (flush_ex) begin
            w_state_n = IDLE;
            w_vl_n    = '0;
            w_eidx_n  = '0;
            w_tag_n   = '0;
        end else if (!stall_ex) begin
            case (r_state)
                RUN: begin
                    w_eidx_n = r_eidx + VL_W'(LANES);
                    if (w_last) begin
                        w_state_n = IDLE;
                    end
                end
                EMPTY: begin
                    w_state_n = IDLE;
                end
                default: begin
                end
            endcase
            // Accept overrides the RUN advance when it lands on the last group.
            if (w_accept) begin
                w_vl_n    = w_vl_clamp;
                w_eidx_n  = '0;
                w_tag_n   = bus.in_tag;
                w_state_n = (w_vl_clamp == '0) ? EMPTY : RUN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_vl    <= '0;
            r_eidx  <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_n;
            r_vl    <= w_vl_n;
            r_eidx  <= w_eidx_n;
            r_tag   <= w_tag_n;
        end
    end

endmodule

// File: doc/rv32v_ex_sequencer.md
# rv32v_ex_sequencer

Vector execute-stage element sequencer for the rv32v pipeline. It accepts one decoded vector instruction at a time from decode, then steps through the instruction's `vl` elements in groups of `LANES` and drives lane enables to the execute lanes. It produces the `busy_ex` signal that the vector hazard unit consumes, and it obeys the `stall_ex` and `flush_ex` signals that the hazard unit returns.

## Interface
Parameters:
- `LANES`, 2: elements processed per cycle (power of two).
- `VLMAX`, 32: maximum elements per instruction.
- `VL_W`, `$clog2(VLMAX+1)`: width of element counts and indices.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  sequencer accepts this cycle.
- `in_vl`  in  VL_W  element count; values above `VLMAX` are clamped to `VLMAX`.
- `in_tag`  in  5  destination register (vd), carried through unchanged.
- `stall_ex`  in  1  hold from hazard unit.
- `flush_ex`  in  1  kill from hazard unit (csr_update).
- `busy_ex`  out  1  multi-cycle instruction still occupying execute.
- `out_valid`  out  1  element group valid to lanes.
- `out_eidx`  out  VL_W  index of the first element in the group.
- `out_mask`  out  LANES  lane enables; bit i is set when `out_eidx+i < vl`.
- `out_last`  out  1  final group of the instruction.
- `out_tag`  out  5  tag of the active instruction.
- `done`  out  1  one-cycle retire pulse.

## Operation
- States: IDLE, RUN, EMPTY.
- Accept occurs when `in_valid & in_ready`. Registers `vl_q`, `eidx_q`, `tag_q` load as follows: `vl_q` gets the clamped `in_vl`, `eidx_q` gets 0, `tag_q` gets `in_tag`.
  - If `vl == 0`, next state is EMPTY.
  - Otherwise, next state is RUN.
- `in_ready = !RST & !flush_ex & !stall_ex & (IDLE | (RUN & out_last))`.
  - Back-to-back issue is allowed on the last group.
- RUN:
  - `out_valid = 1`; `out_eidx = eidx_q`; `out_tag = tag_q`; `out_mask` is per the rule above.
  - `out_last = (eidx_q + LANES >= vl_q)`, computed at `VL_W+1` bits so the sum never wraps.
  - When not stalled: `eidx_q += LANES`.
  - On the last group when not stalled: go to IDLE, or reload if a new instruction is accepted the same cycle.
- EMPTY: `out_valid = 0`. When `!stall_ex`, pulse `done` and go to IDLE. No groups are issued.
- `busy_ex = RUN & !out_last`.
- `done = !flush_ex & !stall_ex & ((RUN & out_last) | EMPTY)`.
- `stall_ex`: all registers hold. Outputs stay stable, so the same group is re-presented each stalled cycle. No accept occurs and no `done` pulses.
- `flush_ex` has priority over stall, accept and advance:
  - Next state is IDLE; `eidx_q`, `vl_q`, `tag_q` clear to 0.
  - No `done` pulse for the killed instruction.
- Outputs in IDLE: all zero.

## Timing
- Reset: state IDLE; all registers 0. `busy_ex`, `out_valid`, `out_eidx`, `out_mask`, `out_last`, `out_tag`, `done` are all 0. `in_ready` is 0 while `RST` is high and 1 in the first cycle after, unless stall or flush is active.
- Accept in cycle N: the first group is visible in cycle N+1.
- Unstalled instruction: occupies `ceil(vl/LANES)` cycles. `done` coincides with the last group.
- `vl = 0`: `done` appears in cycle N+1.
- Each stall cycle adds one cycle of latency.
- Flush in cycle F: `out_valid = 0` from F+1.
- `RST` asserted mid-instruction: the same effect as flush, plus zeroed outputs in the next cycle.
- `busy_ex` is combinational from state. The hazard unit uses it in the same cycle to stall decode and fetch.

## Structure
- Shared package `rv32v_seq_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, EMPTY};
  - default `LANES`, `VLMAX`;
  - group struct (`eidx`, `mask`, `last`, `tag`).
- Sub-module `rv32v_lane_mask_gen`: combinational. Inputs are `eidx`, `vl`; outputs are `mask` and `last`. Parameterized by `LANES` and `VL_W`.
- Top: FSM, counters and handshake logic only.

## Test plan
- `vl=5` accepted at cycle 0, no stall. Required cycle by cycle:
  - cycles 1–3: `eidx` = 0, 2, 4; `mask` = 11, 11, 01;
  - `last` only at cycle 3; `busy_ex` = 1, 1, 0;
  - `done` at cycle 3; `out_tag` equals `in_tag` throughout.
- Same instruction with `stall_ex` high in cycles 2–3. Required:
  - `eidx=2`, `mask=11` held for cycles 2–4;
  - `eidx=4` in cycle 5; `done` in cycle 5 only;
  - `in_ready` = 0 during the stall.
- `vl=8`, `flush_ex` in cycle 2 (`eidx=2`). Required:
  - cycle 3: `out_valid=0`, `busy_ex=0`, `eidx` reset;
  - no `done`; a new instruction is accepted in cycle 3 and starts at `eidx=0`.
- `vl=0` accepted at cycle 0. Required:
  - `out_valid` never rises; `done` is high in cycle 1 only.
- Back-to-back: `vl=2` at cycle 0, then `vl=3` (`in_valid` held). Required:
  - second accept in cycle 1; groups in cycles 2–3 with masks 11, 01;
  - no bubble; `done` in cycles 1 and 3.
- `vl=40` clamps to 32. Required:
  - 16 groups; the final group has `eidx=30`, `mask=11`, `last=1`.
- `RST` in cycle 2 of a `vl=8` instruction. Required:
  - cycle 3: all outputs 0; no `done`.
